// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the 5-stage ARM pipeline: RAW bubbles, branch flush, memory wait freeze.
// Optional macro HAZARD_FORWARDING_EN limits RAW detection to load-use on the EXE slot.
module hazard_stall_controller #(
  parameter int REG_ADDR_W  = 4,
  parameter int STALL_CNT_W = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rn,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   id_two_src,
  input  logic                   id_uses_rn,
  input  logic [REG_ADDR_W-1:0]  id_dest,
  input  logic                   id_wb_en,
  input  logic                   id_mem_r_en,
  input  logic                   id_mem_w_en,
  input  logic                   exe_branch_taken,
  input  logic                   mem_ready,
  output logic                   hazard,
  output logic                   freeze_if,
  output logic                   flush,
  output logic                   freeze_all,
  output logic                   mem_req,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic                  wb;
    logic [REG_ADDR_W-1:0] dest;
    logic                  mr;
    logic                  mw;
  } slot_t;

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  slot_t                  exe_q, exe_d;
  slot_t                  mem_q, mem_d;
  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic                   rn_hit;
  logic                   src2_hit;
  logic                   raw;
  logic                   issue;

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time.
  assign rn_hit   = exe_q.wb & exe_q.mr & (exe_q.dest == id_rn);
  assign src2_hit = exe_q.wb & exe_q.mr & (exe_q.dest == id_src2);

  logic unused_mem;
  assign unused_mem = ^{mem_q.wb, mem_q.dest};
`else
  assign rn_hit   = (exe_q.wb & (exe_q.dest == id_rn))
                  | (mem_q.wb & (mem_q.dest == id_rn));
  assign src2_hit = (exe_q.wb & (exe_q.dest == id_src2))
                  | (mem_q.wb & (mem_q.dest == id_src2));
`endif

  assign mem_req = mem_q.mr | mem_q.mw;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    freeze_all = 1'b0;
    unique case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          freeze_all = 1'b1;
          state_d    = MEM_WAIT;
          cnt_d      = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else begin
          freeze_all = 1'b1;
          if (cnt_q != TIMEOUT) cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
    if (freeze_all && (cnt_d == TIMEOUT)) err_d = 1'b1;
  end

  // Gated by rst so every output reads 0 while reset is held.
  assign flush     = rst & exe_branch_taken & ~freeze_all;
  assign raw       = id_valid
                   & ((id_uses_rn & rn_hit) | (id_two_src & src2_hit));
  assign hazard    = raw & ~flush & ~freeze_all;
  assign freeze_if = hazard | freeze_all;
  assign issue     = id_valid & ~hazard & ~flush;

  always_comb begin
    exe_d = exe_q;
    mem_d = mem_q;
    if (!freeze_all) begin
      mem_d = exe_q;
      exe_d = '0;
      if (issue) begin
        exe_d.wb   = id_wb_en;
        exe_d.dest = id_dest;
        exe_d.mr   = id_mem_r_en;
        exe_d.mw   = id_mem_w_en;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (freeze_if && (stall_q != '1)) begin
      stall_d = stall_q + STALL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q   <= '0;
      mem_q   <= '0;
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      exe_q   <= exe_d;
      mem_q   <= mem_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign mem_err     = err_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: directed cases plus random traffic
// checked every cycle against an in-bench pipeline model.
module tb_hazard_stall_controller;

  localparam int TO = 4;
  localparam int SAT = 65535;
`ifdef HAZARD_FORWARDING_EN
  localparam int ADD_HZ = 0;
  localparam int LDR_HZ = 1;
`else
  localparam int ADD_HZ = 2;
  localparam int LDR_HZ = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid;
  logic [3:0]  id_rn;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic        id_uses_rn;
  logic [3:0]  id_dest;
  logic        id_wb_en;
  logic        id_mem_r_en;
  logic        id_mem_w_en;
  logic        exe_branch_taken;
  logic        mem_ready;
  logic        hazard;
  logic        freeze_if;
  logic        flush;
  logic        freeze_all;
  logic        mem_req;
  logic        mem_err;
  logic [15:0] stall_count;

  hazard_stall_controller #(
    .REG_ADDR_W(4),
    .STALL_CNT_W(16),
    .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_rn(id_rn),
    .id_src2(id_src2),
    .id_two_src(id_two_src),
    .id_uses_rn(id_uses_rn),
    .id_dest(id_dest),
    .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en),
    .exe_branch_taken(exe_branch_taken),
    .mem_ready(mem_ready),
    .hazard(hazard),
    .freeze_if(freeze_if),
    .flush(flush),
    .freeze_all(freeze_all),
    .mem_req(mem_req),
    .mem_err(mem_err),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    bit wb;
    int dest;
    bit mr;
    bit mw;
  } ent_t;

  ent_t pipe[2];
  int   m_wait;
  bit   m_err;
  int   m_stall;
  bit   en = 1'b0;
  bit   e_hz, e_fi, e_fl, e_fa, e_mreq, e_raw;

  function automatic bit hit(input int r, input ent_t ex, input ent_t me);
`ifdef HAZARD_FORWARDING_EN
    return ex.wb && ex.mr && ex.dest == r;
`else
    return (ex.wb && ex.dest == r) || (me.wb && me.dest == r);
`endif
  endfunction

  // The memory stage stays occupied while frozen, so a stall is simply
  // "memory op in MEM and memory not ready".
  always_comb begin
    e_mreq = rst && (pipe[1].mr || pipe[1].mw);
    e_fa   = e_mreq && !mem_ready;
    e_fl   = rst && exe_branch_taken && !e_fa;
    e_raw  = id_valid &&
             ((id_uses_rn && hit(int'(id_rn), pipe[0], pipe[1])) ||
              (id_two_src && hit(int'(id_src2), pipe[0], pipe[1])));
    e_hz   = rst && e_raw && !e_fl && !e_fa;
    e_fi   = e_hz || e_fa;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe[0] <= '{default: 0};
      pipe[1] <= '{default: 0};
      m_wait  <= 0;
      m_err   <= 1'b0;
      m_stall <= 0;
    end else begin
      m_stall <= (e_fi && m_stall < SAT) ? m_stall + 1 : m_stall;
      m_wait  <= e_fa ? m_wait + 1 : 0;
      if (e_fa && m_wait + 1 >= TO) m_err <= 1'b1;
      if (!e_fa) begin
        pipe[1] <= pipe[0];
        if (id_valid && !e_hz && !e_fl)
          pipe[0] <= '{wb: id_wb_en, dest: int'(id_dest),
                       mr: id_mem_r_en, mw: id_mem_w_en};
        else
          pipe[0] <= '{default: 0};
      end
    end
  end

  always @(negedge clk) begin
    if (en) begin
      chk("hazard", hazard, e_hz);
      chk("freeze_if", freeze_if, e_fi);
      chk("flush", flush, e_fl);
      chk("freeze_all", freeze_all, e_fa);
      chk("mem_req", mem_req, e_mreq);
      chk("mem_err", mem_err, m_err);
      chk("stall_count", stall_count, m_stall);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid         = 1'b0;
    id_rn            = 4'd0;
    id_src2          = 4'd0;
    id_two_src       = 1'b0;
    id_uses_rn       = 1'b0;
    id_dest          = 4'd0;
    id_wb_en         = 1'b0;
    id_mem_r_en      = 1'b0;
    id_mem_w_en      = 1'b0;
    exe_branch_taken = 1'b0;
  endtask

  task automatic issue_op(input int d, input bit ld);
    idle();
    id_valid    = 1'b1;
    id_dest     = 4'(d);
    id_wb_en    = 1'b1;
    id_mem_r_en = ld;
  endtask

  task automatic pair(input string nm, input int r, input bit ld,
                      input int exp_hz, input int base);
    int n;
    issue_op(r, ld);
    tick();
    idle();
    id_valid   = 1'b1;
    id_uses_rn = 1'b1;
    id_rn      = 4'(r);
    id_dest    = 4'(r + 1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!hazard) break;
      n++;
      tick();
    end
    chk({nm, "_hz_cycles"}, n, exp_hz);
    chk({nm, "_stall"}, stall_count, base + exp_hz);
    tick();
    idle();
    repeat (3) tick();
  endtask

  initial begin
    idle();
    mem_ready = 1'b1;
    #2 rst = 1'b0;
    en = 1'b1;
    exe_branch_taken = 1'b1;
    @(negedge clk);
    chk("rst_flush", flush, 0);
    chk("rst_hazard", hazard, 0);
    chk("rst_freeze_all", freeze_all, 0);
    chk("rst_stall", stall_count, 0);
    tick();
    idle();
    rst = 1'b1;
    repeat (2) tick();

    pair("add", 1, 1'b0, ADD_HZ, 0);
    pair("ldr", 2, 1'b1, LDR_HZ, ADD_HZ);

    issue_op(5, 1'b0);
    tick();
    idle();
    id_valid         = 1'b1;
    id_uses_rn       = 1'b1;
    id_rn            = 4'd5;
    id_dest          = 4'd6;
    id_wb_en         = 1'b1;
    exe_branch_taken = 1'b1;
    @(negedge clk);
    chk("br_flush", flush, 1);
    chk("br_hazard", hazard, 0);
    tick();
    idle();
    id_valid   = 1'b1;
    id_uses_rn = 1'b1;
    id_rn      = 4'd6;
    @(negedge clk);
    chk("br_bubble", hazard, 0);
    tick();
    idle();
    repeat (3) tick();

    issue_op(8, 1'b1);
    tick();
    idle();
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wait_freeze", freeze_all, 1);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("wait_release", freeze_all, 0);
    chk("wait_req", mem_req, 1);
    tick();
    @(negedge clk);
    chk("wait_adv", mem_req, 0);
    chk("wait_stall", stall_count, ADD_HZ + LDR_HZ + 3);
    chk("wait_noerr", mem_err, 0);
    tick();

    issue_op(9, 1'b1);
    tick();
    idle();
    tick();
    mem_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("to_err", mem_err, (k >= TO) ? 1 : 0);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("to_sticky", mem_err, 1);
    tick();
    @(negedge clk);
    chk("to_sticky2", mem_err, 1);
    tick();

    for (int i = 0; i < 2000; i++) begin
      id_valid         = ($urandom_range(0, 9) < 8);
      id_rn            = 4'($urandom_range(0, 3));
      id_src2          = 4'($urandom_range(0, 3));
      id_two_src       = 1'($urandom_range(0, 1));
      id_uses_rn       = 1'($urandom_range(0, 1));
      id_dest          = 4'($urandom_range(0, 3));
      id_wb_en         = 1'($urandom_range(0, 1));
      id_mem_r_en      = ($urandom_range(0, 3) == 0);
      id_mem_w_en      = ($urandom_range(0, 3) == 0);
      exe_branch_taken = ($urandom_range(0, 9) == 0);
      mem_ready        = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle();
    mem_ready = 1'b1;
    repeat (5) tick();

    issue_op(3, 1'b1);
    tick();
    idle();
    tick();
    mem_ready = 1'b0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    chk("sat_stall", stall_count, SAT);
    chk("sat_freeze", freeze_all, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_freeze_all", freeze_all, 0);
    chk("arst_freeze_if", freeze_if, 0);
    chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_err", mem_err, 0);
    chk("arst_stall", stall_count, 0);
    tick();
    mem_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage ARM core (IF/ID/EXE/MEM/WB).
- Keeps a private scoreboard of in-flight destination registers for EXE and MEM.
- Drives the ID stage `HazardIn` bubble, IF/ID freeze and flush on taken branches, and a global freeze while the data memory handshake is outstanding.
- Sits beside the ID stage; its inputs are the ID-stage decode fields and the EXE-stage branch flag.

Parameters:
- REG_ADDR_W, 4, register index width
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- MEM_TIMEOUT, 255, MEM_WAIT cycles before `mem_err` is raised (range 1..255)

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction that passed its condition check
- id_rn  in  REG_ADDR_W  first source register
- id_src2  in  REG_ADDR_W  second source register (Rm, or Rd for stores)
- id_two_src  in  1  `id_src2` is read
- id_uses_rn  in  1  `id_rn` is read
- id_dest  in  REG_ADDR_W  destination register
- id_wb_en  in  1  instruction writes back
- id_mem_r_en  in  1  instruction is a load
- id_mem_w_en  in  1  instruction is a store
- exe_branch_taken  in  1  EXE resolved a taken branch this cycle
- mem_ready  in  1  data memory has completed the current access
- hazard  out  1  to ID `HazardIn`: bubble ID, hold PC and IF/ID
- freeze_if  out  1  hold PC and the IF/ID register
- flush  out  1  clear IF/ID and the ID/EXE control fields
- freeze_all  out  1  hold every pipeline register
- mem_req  out  1  MEM stage holds a load or store
- mem_err  out  1  sticky memory timeout
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (`rst`=0, asynchronous):
  - Both scoreboard slots clear (valid=0).
  - FSM enters RUN; wait counter is 0.
  - `mem_err`=0 and `stall_count`=0.
  - All combinational outputs evaluate to 0.
  - Reset asserted mid-wait aborts the wait immediately.
- Scoreboard:
  - Slots are EXE_S and MEM_S. Each holds {wb, dest, mr, mw}.
  - When `freeze_all`=0, each rising edge does MEM_S<=EXE_S.
  - On the same edge EXE_S<={id_wb_en, id_dest, id_mem_r_en, id_mem_w_en} if `id_valid` & ~`hazard` & ~`flush`; otherwise EXE_S<=0 (bubble).
  - When `freeze_all`=1, both slots hold.
- Hazard (combinational):
  - match(r) = (EXE_S.wb & EXE_S.dest==r) | (MEM_S.wb & MEM_S.dest==r).
  - raw = `id_valid` & ((`id_uses_rn` & match(id_rn)) | (`id_two_src` & match(id_src2))).
  - `hazard` = raw & ~`flush` & ~`freeze_all`.
  - `freeze_if` = `hazard` | `freeze_all`.
  - WB-stage writes are not checked: the register file is write-before-read.
- Flush:
  - `flush` = `exe_branch_taken` & ~`freeze_all`, for one cycle per asserted cycle.
  - Flush beats hazard in the same cycle.
- Memory FSM, states RUN, MEM_WAIT:
  - `mem_req` = MEM_S.mr | MEM_S.mw.
  - RUN, with `mem_req` & ~`mem_ready`: `freeze_all`=1 in that same cycle; go to MEM_WAIT; counter<=1.
  - RUN, with `mem_req` & `mem_ready`: no freeze (zero-wait access).
  - MEM_WAIT: `freeze_all`=~`mem_ready`. On `mem_ready`, return to RUN; the pipeline advances on that edge.
  - MEM_WAIT, otherwise: counter increments. When counter reaches MEM_TIMEOUT, `mem_err`<=1 (sticky until reset) and the FSM keeps waiting.
- Stall counter:
  - Increments on every edge where `freeze_if`=1.
  - Saturates at all-ones and never wraps.

Optional Feature:
- Macro: HAZARD_FORWARDING_EN.
- Defined: EXE has a forwarding unit.
  - match(r) = EXE_S.wb & EXE_S.mr & EXE_S.dest==r (load-use only).
  - MEM_S is ignored for hazard purposes.
- Undefined: the full EXE+MEM match defined above applies.

Test Plan:
- Reset then release; ADD R1 dest (wb=1) issued; next instruction reads id_rn=1 → `hazard`=1 for 2 cycles (EXE and MEM slots), instruction issues on cycle 3, `stall_count`=2.
- Same sequence with HAZARD_FORWARDING_EN → `hazard`=0 for the ALU producer. Then LDR R2 followed by a reader of R2 → `hazard`=1 for exactly 1 cycle.
- `exe_branch_taken`=1 in the same cycle as a raw hazard → `flush`=1, `hazard`=0, EXE_S becomes a bubble next cycle.
- Load reaches MEM, `mem_ready` low for 3 cycles → `freeze_all`=1 for 3 cycles, slots unchanged, `stall_count`+=3, pipeline advances on the 4th edge.
- MEM_TIMEOUT=4 with `mem_ready` held low → `mem_err`=1 after 4 wait cycles and stays 1 after `mem_ready` rises. `rst`=0 mid-wait → all outputs 0 asynchronously.
- Force `stall_count` near all-ones via a long memory wait → holds at 0xFFFF and does not wrap.
